// File: rtl/hc_ser_rx_dec.sv
// Serial Hamming(7,4) receiver: reassembles 7-bit codewords, corrects single-bit errors,
// and presents data on a one-entry valid/ready output. Optional macro HC_ERR_CNT_EN adds o_err_cnt.
module hc_ser_rx_dec #(
   parameter int unsigned DATA_WD = 4,
   parameter int unsigned CHK_WD  = 3
`ifdef HC_ERR_CNT_EN
   ,
   parameter int unsigned CNT_WD  = 8
`endif
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_sync,
   input  logic               i_ser_bit,
   input  logic               i_ser_vld,
   output logic               o_ser_rdy,
   output logic [DATA_WD-1:0] o_data,
   output logic               o_err,
   output logic [CHK_WD-1:0]  o_err_pos,
   output logic               o_vld,
   input  logic               i_rdy
`ifdef HC_ERR_CNT_EN
   ,
   output logic [CNT_WD-1:0]  o_err_cnt
`endif
);

   localparam int unsigned CW_WD  = DATA_WD + CHK_WD;
   localparam int unsigned POS_WD = 3;
   localparam logic [POS_WD-1:0] LAST_POS = POS_WD'(CW_WD - 1);

   logic [POS_WD-1:0]  cnt_q, cnt_d;
   logic [CW_WD-1:0]   sr_q, sr_d;
   logic [CW_WD-1:0]   cw, cw_fix;
   logic [CHK_WD-1:0]  syn;
   logic               accept, complete;
   logic [DATA_WD-1:0] data_d;
   logic               err_d, vld_d;
   logic [CHK_WD-1:0]  pos_d;

   // Handshake, codeword assembly, syndrome and correction
   always_comb begin
      o_ser_rdy = !((cnt_q == LAST_POS) && o_vld && !i_rdy);
      accept    = i_ser_vld && o_ser_rdy;
      complete  = accept && !i_sync && (cnt_q == LAST_POS);

      cw            = sr_q;
      cw[CW_WD-1]   = i_ser_bit;
      syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
      syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
      syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];

      cw_fix = cw;
      for (int unsigned i = 0; i < CW_WD; i++) begin
         if (syn == CHK_WD'(i + 1)) cw_fix[i] = ~cw[i];
      end

      cnt_d = cnt_q;
      sr_d  = sr_q;
      if (i_sync) begin
         cnt_d = '0;
         if (accept) begin
            sr_d[0] = i_ser_bit;
            cnt_d   = POS_WD'(1);
         end
      end else if (accept) begin
         sr_d[cnt_q] = i_ser_bit;
         cnt_d       = complete ? '0 : cnt_q + POS_WD'(1);
      end

      data_d = o_data;
      err_d  = o_err;
      pos_d  = o_err_pos;
      vld_d  = o_vld;
      if (complete) begin
         data_d = {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
         err_d  = (syn != '0);
         pos_d  = syn;
         vld_d  = 1'b1;
      end else if (o_vld && i_rdy) begin
         vld_d  = 1'b0;
      end
   end

   // Bit counter, shift register and output register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q     <= '0;
         sr_q      <= '0;
         o_data    <= '0;
         o_err     <= 1'b0;
         o_err_pos <= '0;
         o_vld     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         sr_q      <= sr_d;
         o_data    <= data_d;
         o_err     <= err_d;
         o_err_pos <= pos_d;
         o_vld     <= vld_d;
      end
   end

`ifdef HC_ERR_CNT_EN
   // Saturating count of corrected words, cleared only by reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_err_cnt <= '0;
      end else if (complete && (syn != '0) && (o_err_cnt != '1)) begin
         o_err_cnt <= o_err_cnt + CNT_WD'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hc_ser_rx_dec.sv
// Scoreboard bench for hc_ser_rx_dec: stimulus pushes expected words, a negedge monitor
// pops and compares. Define HC_ERR_CNT_EN to also check o_err_cnt with CNT_WD = 2.
module tb_hc_ser_rx_dec;

   typedef struct packed {
      logic [3:0] data;
      logic       err;
      logic [2:0] pos;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sync = 1'b0;
   logic       ser_bit = 1'b0;
   logic       ser_vld = 1'b0;
   logic       ser_rdy;
   logic [3:0] data;
   logic       err;
   logic [2:0] err_pos;
   logic       vld;
   logic       rdy = 1'b1;
`ifdef HC_ERR_CNT_EN
   logic [1:0] err_cnt;
`endif

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   frame_len = 0;
   int   exp_ecnt = 0;
   int   rdy_mode = 2;

`ifdef HC_ERR_CNT_EN
   hc_ser_rx_dec #(.DATA_WD(4), .CHK_WD(3), .CNT_WD(2)) dut (
`else
   hc_ser_rx_dec #(.DATA_WD(4), .CHK_WD(3)) dut (
`endif
      .i_clk(clk), .i_rst(rst), .i_sync(sync), .i_ser_bit(ser_bit), .i_ser_vld(ser_vld),
      .o_ser_rdy(ser_rdy), .o_data(data), .o_err(err), .o_err_pos(err_pos), .o_vld(vld),
      .i_rdy(rdy)
`ifdef HC_ERR_CNT_EN
      , .o_err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Hamming(7,4) encoder; index i holds codeword position i+1
   function automatic logic [6:0] encode(input logic [3:0] d);
      logic [6:0] c;
      c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
      c[0] = d[0] ^ d[1] ^ d[3];
      c[1] = d[0] ^ d[2] ^ d[3];
      c[3] = d[1] ^ d[2] ^ d[3];
      return c;
   endfunction

   // Called at a rising edge; returns at the rising edge where the bit is taken
   task automatic send_bit(input logic b, input logic s);
      int n = 0;
      #1;
      ser_vld = 1'b1; ser_bit = b; sync = s;
      @(negedge clk);
      while (!ser_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ser_rdy) begin
         checks++; errors++;
         $display("FAIL ser_accept timeout got ser_rdy 0 expected 1");
      end
      @(posedge clk);
      frame_len = s ? 1 : ((frame_len == 6) ? 0 : frame_len + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         #1; ser_vld = 1'b0; sync = 1'b0;
         @(posedge clk);
      end
   endtask

   task automatic junk(input int n);
      for (int i = 0; i < n; i++) send_bit(1'($urandom), 1'b0);
   endtask

   // flip = codeword position to corrupt (0 = clean)
   task automatic send_word(input logic [3:0] d, input int flip, input int gapmax, input logic first_sync);
      logic [6:0] cw = encode(d);
      exp_t e;
      if (flip != 0) cw[flip-1] = ~cw[flip-1];
      for (int i = 0; i < 7; i++) begin
         send_bit(cw[i], (i == 0) && first_sync);
         if (i != 6 && gapmax > 0) idle(int'($urandom_range(0, gapmax)));
      end
      e.data = d; e.err = (flip != 0); e.pos = 3'(flip);
      exp_q.push_back(e);
      if (flip != 0 && exp_ecnt < 3) exp_ecnt++;
   endtask

   task automatic do_reset();
      #3;
      rst = 1'b1; ser_vld = 1'b0; sync = 1'b0;
      #1;
      check("rst_vld", 32'(vld), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_pos", 32'(err_pos), 32'd0);
      check("rst_ser_rdy", 32'(ser_rdy), 32'd1);
`ifdef HC_ERR_CNT_EN
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
      exp_q.delete();
      frame_len = 0;
      exp_ecnt  = 0;
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
   endtask

   // Downstream ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         rdy = (rdy_mode == 0) ? 1'($urandom_range(0, 1)) : (rdy_mode == 2);
      end
   end

   // Monitor: compares DUT presentation against the scoreboard head
   always @(negedge clk) begin
      if (!rst) begin
         check("vld", 32'(vld), 32'(exp_q.size() != 0));
         check("ser_rdy", 32'(ser_rdy), 32'(!(frame_len == 6 && exp_q.size() != 0 && !rdy)));
         if (vld && exp_q.size() != 0) begin
            check("data", 32'(data), 32'(exp_q[0].data));
            check("err", 32'(err), 32'(exp_q[0].err));
            check("err_pos", 32'(err_pos), 32'(exp_q[0].pos));
            if (rdy) void'(exp_q.pop_front());
         end
`ifdef HC_ERR_CNT_EN
         check("err_cnt", 32'(err_cnt), 32'(exp_ecnt));
`endif
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      #12 rst = 1'b0;
      @(posedge clk);
      check("init_vld", 32'(vld), 32'd0);

      rdy_mode = 2;
      send_word(4'b1011, 0, 0, 1'b0);
      idle(3);
      send_word(4'b1011, 5, 0, 1'b0);
      idle(3);

      rdy_mode = 1;
      fork
         begin
            send_word(4'h6, 0, 0, 1'b0);
            send_word(4'h9, 2, 0, 1'b0);
         end
         begin
            repeat (25) @(posedge clk);
            rdy_mode = 2;
         end
      join
      idle(4);

      junk(3);
      send_word(4'h0, 0, 0, 1'b1);
      idle(4);

      junk(4);
      do_reset();
      send_word(4'hC, 0, 0, 1'b0);
      idle(4);

      rdy_mode = 0;
      for (int n = 0; n < 150; n++) begin
         logic [3:0] d = 4'($urandom);
         int flip = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
         if ($urandom_range(0, 7) == 0) begin
            junk(int'($urandom_range(0, 5)));
            send_word(d, flip, 2, 1'b1);
         end else begin
            send_word(d, flip, 2, 1'b0);
         end
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end

      rdy_mode = 2;
      idle(10);
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
